// File: rtl/vga_timing_pkg.sv
// Shared timing defaults, phase encoding and helpers for the VGA raster generator.
// Defaults describe 640x480@60 on an 800x525 raster.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FRONT  = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BACK   = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_ACTIVE = 480;
    localparam int V_FRONT  = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BACK   = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_t;

    function automatic logic in_range(
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle from the timing generator to the line/colour renderers.
// master drives, slave observes.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic               hsync;
    logic               vsync;
    logic               active;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic               line_start;
    logic               frame_start;
    logic               pix_ce;

    modport master (
        output hsync,
        output vsync,
        output active,
        output pixel_x,
        output pixel_y,
        output line_start,
        output frame_start,
        output pix_ce
    );

    modport slave (
        input hsync,
        input vsync,
        input active,
        input pixel_x,
        input pixel_y,
        input line_start,
        input frame_start,
        input pix_ce
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus ACT/FP/SYNC/BP phase FSM.
// Used for both the horizontal and the vertical axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FRONT  = 16,
    parameter int SYNC   = 96,
    parameter int BACK   = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               adv,
    output logic [COORD_W-1:0] cnt,
    output phase_t             phase,
    output logic               wrap,
    output logic               sync_hit
);

    localparam int TOTAL = ACTIVE + FRONT + SYNC + BACK;

    localparam logic [COORD_W-1:0] LAST   = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] E_ACT  = COORD_W'(ACTIVE - 1);
    localparam logic [COORD_W-1:0] E_FP   = COORD_W'(ACTIVE + FRONT - 1);
    localparam logic [COORD_W-1:0] S_LO   = COORD_W'(ACTIVE + FRONT);
    localparam logic [COORD_W-1:0] E_SYNC = COORD_W'(ACTIVE + FRONT + SYNC - 1);

    // Each phase needs at least one count or the FSM would skip it.
    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_len
        $error("vga_axis_counter: every phase must be at least 1 long");
    end

    phase_t phase_nxt;

    assign wrap     = (cnt == LAST);
    assign sync_hit = in_range(cnt, S_LO, E_SYNC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (adv) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PH_ACT;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (adv) begin
            unique case (phase)
                PH_ACT:  if (cnt == E_ACT)  phase_nxt = PH_FP;
                PH_FP:   if (cnt == E_FP)   phase_nxt = PH_SYNC;
                PH_SYNC: if (cnt == E_SYNC) phase_nxt = PH_BP;
                PH_BP:   if (wrap)          phase_nxt = PH_ACT;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: hsync/vsync, active enable, pixel x/y, line/frame pulses.
// Define VGA_TIMING_CLKDIV_EN to run the raster at half the clk rate via pix_ce.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int   H_FRONT  = vga_timing_pkg::H_FRONT,
    parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int   H_BACK   = vga_timing_pkg::H_BACK,
    parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int   V_FRONT  = vga_timing_pkg::V_FRONT,
    parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int   V_BACK   = vga_timing_pkg::V_BACK,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    vga_timing_if.master vga
);

    localparam int HT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (HT > 1024) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL %0d exceeds 1024", HT);
    end
    if (VT > 1024) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL %0d exceeds 1024", VT);
    end

    logic ce;

`ifdef VGA_TIMING_CLKDIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ce <= 1'b0;
        end else begin
            ce <= ~ce;
        end
    end
`else
    assign ce = 1'b1;
`endif

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    phase_t             h_ph;
    phase_t             v_ph;
    logic               h_wrap;
    logic               h_hit;
    logic               v_hit;
    logic               v_wrap_unused;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (ce),
        .cnt      (h_cnt),
        .phase    (h_ph),
        .wrap     (h_wrap),
        .sync_hit (h_hit)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (ce & h_wrap),
        .cnt      (v_cnt),
        .phase    (v_ph),
        .wrap     (v_wrap_unused),
        .sync_hit (v_hit)
    );

    logic vis;
    logic h_zero;

    assign vis    = (h_ph == PH_ACT) && (v_ph == PH_ACT);
    assign h_zero = (h_cnt == '0);

    logic               hs_q;
    logic               vs_q;
    logic               act_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic               ls_q;
    logic               fs_q;

    // Decode the pre-tick counter state so every output shares one latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            act_q <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
        end else if (ce) begin
            hs_q  <= h_hit ? SYNC_POL : ~SYNC_POL;
            vs_q  <= v_hit ? SYNC_POL : ~SYNC_POL;
            act_q <= vis;
            x_q   <= vis ? h_cnt : '0;
            y_q   <= vis ? v_cnt : '0;
            ls_q  <= h_zero;
            fs_q  <= h_zero && (v_cnt == '0);
        end
    end

    assign vga.hsync       = hs_q;
    assign vga.vsync       = vs_q;
    assign vga.active      = act_q;
    assign vga.pixel_x     = x_q;
    assign vga.pixel_y     = y_q;
    assign vga.line_start  = ls_q;
    assign vga.frame_start = fs_q;
    assign vga.pix_ce      = ce;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default raster plus two small rasters
// (active-low and active-high sync) compared every clk against an arithmetic model.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

`ifdef VGA_TIMING_CLKDIV_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic [9:0] x;
        logic [9:0] y;
        logic       ls;
        logic       fs;
        logic       ce;
    } obs_t;

    typedef struct {
        int   ha, hf, hs, hb;
        int   va, vf, vs, vb;
        logic pol;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if vi0 ();
    vga_timing_if vi1 ();
    vga_timing_if vi2 ();

    vga_timing_gen u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vi0)
    );

    vga_timing_gen #(
        .H_ACTIVE (12), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
        .V_ACTIVE (6),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL (1'b0)
    ) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vi1)
    );

    vga_timing_gen #(
        .H_ACTIVE (12), .H_FRONT (3), .H_SYNC (4), .H_BACK (5),
        .V_ACTIVE (6),  .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
        .SYNC_POL (1'b1)
    ) u2 (
        .clk   (clk),
        .rst_n (rst_n),
        .vga   (vi2)
    );

    obs_t o [3];
    assign o[0] = {vi0.hsync, vi0.vsync, vi0.active, vi0.pixel_x, vi0.pixel_y,
                   vi0.line_start, vi0.frame_start, vi0.pix_ce};
    assign o[1] = {vi1.hsync, vi1.vsync, vi1.active, vi1.pixel_x, vi1.pixel_y,
                   vi1.line_start, vi1.frame_start, vi1.pix_ce};
    assign o[2] = {vi2.hsync, vi2.vsync, vi2.active, vi2.pixel_x, vi2.pixel_y,
                   vi2.line_start, vi2.frame_start, vi2.pix_ce};

    // Pixel ticks seen since reset release, and the expected pix_ce level.
    int   t = 0;
    logic mce = (DIV == 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t   <= 0;
            mce <= (DIV == 1);
        end else begin
            if (mce) t <= t + 1;
            if (DIV == 2) mce <= ~mce;
        end
    end

    int checks = 0;
    int fails  = 0;

    function automatic cfg_t cfg_of(input int i);
        cfg_t c;
        if (i == 0) c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        else        c = '{12, 3, 4, 5, 6, 2, 2, 3, (i == 2)};
        return c;
    endfunction

    // Tick tk > 0 presents raster position tk-1; tk == 0 means reset values.
    function automatic obs_t model(input int i, input int tk, input logic ce);
        cfg_t c = cfg_of(i);
        obs_t r;
        int ht, vt, k, h, v;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        r = '0;
        r.ce = ce;
        r.hs = ~c.pol;
        r.vs = ~c.pol;
        if (tk > 0) begin
            k = tk - 1;
            h = k % ht;
            v = (k / ht) % vt;
            r.act = (h < c.ha) && (v < c.va);
            if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) r.hs = c.pol;
            if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) r.vs = c.pol;
            r.x  = r.act ? 10'(h) : 10'd0;
            r.y  = r.act ? 10'(v) : 10'd0;
            r.ls = (h == 0);
            r.fs = (h == 0) && (v == 0);
        end
        return r;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (o[i] !== model(i, 0, DIV == 1)) begin
                fails++;
                $display("FAIL reset dut%0d got %h want %h", i, o[i], model(i, 0, DIV == 1));
            end
        end
        checks++;
        if (o[2].hs !== 1'b0 || o[2].vs !== 1'b0) begin
            fails++;
            $display("FAIL pol1_idle got hs=%b vs=%b want 0 0", o[2].hs, o[2].vs);
        end
    endtask

    task automatic test_first_line();
        int   hs_low = 0;
        int   ls_at[$];
        int   ys[$];
        logic prev_ls = 1'b0;
        rst_n = 1'b1;
        for (int cyc = 1; cyc <= 800 * DIV + 2; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o[i] !== model(i, t, mce)) begin
                    fails++;
                    $display("FAIL first_line dut%0d t=%0d got %h want %h", i, t, o[i], model(i, t, mce));
                end
            end
            if (o[0].hs === 1'b0) hs_low++;
            if (o[0].ls && !prev_ls) begin
                ls_at.push_back(cyc);
                ys.push_back(int'(o[0].y));
            end
            prev_ls = o[0].ls;
        end
        checks++;
        if (hs_low != 96 * DIV) begin
            fails++;
            $display("FAIL hsync_width got %0d clk want %0d", hs_low, 96 * DIV);
        end
        checks++;
        if (ls_at.size() < 2) begin
            fails++;
            $display("FAIL line_start_count got %0d want 2", ls_at.size());
        end else begin
            if (ls_at[0] != DIV || ls_at[1] - ls_at[0] != 800 * DIV || ys[1] != 1) begin
                fails++;
                $display("FAIL line_period first=%0d period=%0d y=%0d want %0d %0d 1",
                         ls_at[0], ls_at[1] - ls_at[0], ys[1], DIV, 800 * DIV);
            end
        end
    endtask

    task automatic test_small_frames();
        int   fs_at[$];
        int   vlow1 = 0;
        int   vhigh2 = 0;
        logic prev_fs = o[1].fs;
        for (int cyc = 0; cyc < 3 * 312 * DIV + 4; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o[i] !== model(i, t, mce)) begin
                    fails++;
                    $display("FAIL small_frames dut%0d t=%0d got %h want %h", i, t, o[i], model(i, t, mce));
                end
            end
            if (o[1].fs && !prev_fs) fs_at.push_back(cyc);
            prev_fs = o[1].fs;
            if (fs_at.size() == 1) begin
                if (o[1].vs === 1'b0) vlow1++;
                if (o[2].vs === 1'b1) vhigh2++;
            end
        end
        checks++;
        if (fs_at.size() < 2) begin
            fails++;
            $display("FAIL frame_start_count got %0d want >=2", fs_at.size());
        end else if (fs_at[1] - fs_at[0] != 312 * DIV) begin
            fails++;
            $display("FAIL frame_period got %0d want %0d", fs_at[1] - fs_at[0], 312 * DIV);
        end
        checks++;
        if (vlow1 != 2 * 24 * DIV || vhigh2 != 2 * 24 * DIV) begin
            fails++;
            $display("FAIL vsync_width got %0d/%0d want %0d", vlow1, vhigh2, 2 * 24 * DIV);
        end
    endtask

    task automatic test_midframe_reset();
        for (int r = 0; r < 4; r++) begin
            int  len;
            int  first_fs;
            bit  found;
            found = (r != 0);
            len   = (r == 0) ? 1700 * DIV : int'($urandom_range(1, 600));
            for (int cyc = 0; cyc < len && !(r == 0 && found); cyc++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (o[i] !== model(i, t, mce)) begin
                        fails++;
                        $display("FAIL pre_reset r%0d dut%0d got %h want %h", r, i, o[i], model(i, t, mce));
                    end
                end
                if (r == 0 && o[0].act && o[0].x == 10'd300 && o[0].y >= 10'd1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                fails++;
                $display("FAIL wait_x300 timeout got x=%0d want 300", o[0].x);
            end
            #2 rst_n = 1'b0;
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (o[i] !== model(i, 0, DIV == 1)) begin
                    fails++;
                    $display("FAIL async_reset r%0d dut%0d got %h want %h", r, i, o[i], model(i, 0, DIV == 1));
                end
            end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            first_fs = -1;
            for (int cyc = 1; cyc <= int'($urandom_range(100, 700)) * DIV; cyc++) begin
                @(negedge clk);
                for (int i = 0; i < 3; i++) begin
                    checks++;
                    if (o[i] !== model(i, t, mce)) begin
                        fails++;
                        $display("FAIL post_reset r%0d dut%0d got %h want %h", r, i, o[i], model(i, t, mce));
                    end
                end
                if (first_fs < 0 && o[0].fs) first_fs = cyc;
            end
            checks++;
            if (first_fs != DIV) begin
                fails++;
                $display("FAIL restart_fs r%0d got clk %0d want %0d", r, first_fs, DIV);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_small_frames();
        test_midframe_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
